// File: rtl/seg7_pkg.sv
// Shared definitions for the six-digit BCD counter and the
// 7-segment decoder and display stages that consume its digits.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4;
    localparam int BCD_MAX    = 9;
    localparam int BUS_W      = NUM_DIGITS * BCD_W;

    typedef logic [BCD_W-1:0] digit_t;

    typedef enum logic {
        READY   = 1'b0,
        HOLDOFF = 1'b1
    } load_state_e;

    // True when every nibble of a packed digit bus is a legal decimal digit
    function automatic logic bcd_ok(input logic [BUS_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*BCD_W +: BCD_W] > digit_t'(BCD_MAX)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered decade of the counter. Steps up or down on request
// and reports a carry/borrow to the next decade in the same cycle.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clr_i,
    input  logic   step_i,
    input  logic   up_i,
    input  logic   load_i,
    input  digit_t load_val_i,
    output digit_t digit_o,
    output logic   carry_o
);

    digit_t digit_q;
    digit_t digit_d;

    // Carry out when stepping past 9 going up or past 0 going down
    always_comb begin
        carry_o = 1'b0;
        if (step_i) begin
            if (up_i) begin
                carry_o = (digit_q == digit_t'(BCD_MAX));
            end else begin
                carry_o = (digit_q == '0);
            end
        end
    end

    // Next decade value: clear beats load beats step
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = load_val_i;
        end else if (step_i) begin
            if (up_i) begin
                if (digit_q == digit_t'(BCD_MAX)) begin
                    digit_d = '0;
                end else begin
                    digit_d = digit_q + digit_t'(1);
                end
            end else begin
                if (digit_q == '0) begin
                    digit_d = digit_t'(BCD_MAX);
                end else begin
                    digit_d = digit_q - digit_t'(1);
                end
            end
        end
    end

    // Decade register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_count_6dig.sv
// Six-digit up/down BCD counter with a 1 Hz prescaler, parallel load
// handshake, leading-zero blanking and a wrap pulse.
module bcd_count_6dig
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                Reset_7Seg_n,
    input  logic                En,
    input  logic                Up,
    input  logic                Clear,
    input  logic                Load_Valid,
    input  logic [BUS_W-1:0]    Load_Value,
    output logic                Load_Ready,
    output logic                Load_Err,
    output logic [BUS_W-1:0]    Digits,
    output logic [NUM_DIGITS-1:0] Blank,
    output logic                Wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    logic          step;

    load_state_e   state_q;
    load_state_e   state_d;
    logic          offer;
    logic          accept;
    logic          reject;

    logic          wrap_q;
    logic          wrap_d;
    logic          err_q;
    logic          err_d;

    digit_t        dig   [NUM_DIGITS];
    logic          carry [NUM_DIGITS];
    logic          chain [NUM_DIGITS];

    // Reset assertion is immediate; release is retimed to the clock
    always_ff @(posedge CLOCK_50 or negedge Reset_7Seg_n) begin
        if (!Reset_7Seg_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign Load_Ready = (state_q == READY);
    assign offer      = Load_Valid && Load_Ready && !Clear;
    assign accept     = offer && bcd_ok(Load_Value);
    assign reject     = offer && !bcd_ok(Load_Value);

    assign tick = En && (presc_q == PRESC_LAST);
    assign step = tick && !Clear && !accept;

    // Load handshake: one holdoff cycle after each accepted load
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            READY:   if (accept) state_d = HOLDOFF;
            HOLDOFF: state_d = READY;
            default: state_d = READY;
        endcase
        if (Clear) begin
            state_d = READY;
        end
    end

    // Load FSM state register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescaler: restarts on clear or load, freezes while disabled
    always_comb begin
        presc_d = presc_q;
        if (Clear || accept) begin
            presc_d = '0;
        end else if (En) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Prescaler register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Ripple chain: each decade steps on the carry of the one below
    always_comb begin
        chain[0] = step;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            chain[i] = carry[i-1];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit u_digit (
            .clk_i      (CLOCK_50),
            .rst_ni     (rst_n),
            .clr_i      (Clear),
            .step_i     (chain[g]),
            .up_i       (Up),
            .load_i     (accept),
            .load_val_i (Load_Value[g*BCD_W +: BCD_W]),
            .digit_o    (dig[g]),
            .carry_o    (carry[g])
        );
        assign Digits[g*BCD_W +: BCD_W] = dig[g];
    end

    assign wrap_d = carry[NUM_DIGITS-1];
    assign err_d  = reject;

    // Status pulses line up with the digit update they describe
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Wrap     = wrap_q;
    assign Load_Err = err_q;

    // Blank a digit when it and every digit above it are zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        Blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (dig[i] == '0);
            Blank[i]   = zero_above;
        end
    end

endmodule

// File: tb/tb_bcd_count_6dig.sv
// Directed and randomized checks of bcd_count_6dig against an
// integer-valued model of the counter behaviour.
module tb_bcd_count_6dig;

    localparam int TD = 4;
    localparam int MODN = 1000000;

    logic        CLOCK_50 = 1'b0;
    logic        Reset_7Seg_n;
    logic        En;
    logic        Up;
    logic        Clear;
    logic        Load_Valid;
    logic [23:0] Load_Value;
    logic        Load_Ready;
    logic        Load_Err;
    logic [23:0] Digits;
    logic [5:0]  Blank;
    logic        Wrap;

    int m_val;
    int m_pre;
    bit m_rdy;
    bit m_wrap;
    bit m_err;
    int vectors;
    int miscompares;
    int wrap_seen;

    bcd_count_6dig #(.TICK_DIV(TD)) dut (
        .CLOCK_50     (CLOCK_50),
        .Reset_7Seg_n (Reset_7Seg_n),
        .En           (En),
        .Up           (Up),
        .Clear        (Clear),
        .Load_Valid   (Load_Valid),
        .Load_Value   (Load_Value),
        .Load_Ready   (Load_Ready),
        .Load_Err     (Load_Err),
        .Digits       (Digits),
        .Blank        (Blank),
        .Wrap         (Wrap)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [23:0] b);
        int r;
        int w;
        r = 0;
        w = 1;
        for (int i = 0; i < 6; i++) begin
            r = r + int'(b[i*4 +: 4]) * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic bit all_dec(input logic [23:0] b);
        for (int i = 0; i < 6; i++) begin
            if (b[i*4 +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [5:0] exp_blank(input int v);
        logic [5:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < 6; i++) begin
            if (v < p) b[i] = 1'b1;
            p = p * 10;
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = 0;
        m_pre  = 0;
        m_rdy  = 1'b1;
        m_wrap = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        bit tk;
        bit off;
        tk     = En && (m_pre == TD - 1);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (Clear) begin
            m_val = 0;
            m_pre = 0;
            m_rdy = 1'b1;
        end else begin
            off = Load_Valid && m_rdy;
            if (off && all_dec(Load_Value)) begin
                m_val = from_bcd(Load_Value);
                m_pre = 0;
                m_rdy = 1'b0;
            end else begin
                m_err = off;
                m_rdy = 1'b1;
                if (tk) begin
                    if (Up) begin
                        m_wrap = (m_val == MODN - 1);
                        m_val  = (m_val + 1) % MODN;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val + MODN - 1) % MODN;
                    end
                end
                if (En) m_pre = tk ? 0 : m_pre + 1;
            end
        end
    endtask

    task automatic check_all();
        chk("digits", Digits, to_bcd(m_val));
        chk("wrap", 24'(Wrap), 24'(m_wrap));
        chk("load_err", 24'(Load_Err), 24'(m_err));
        chk("load_ready", 24'(Load_Ready), 24'(m_rdy));
        chk("blank", 24'(Blank), 24'(exp_blank(m_val)));
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        check_all();
        if (Wrap) wrap_seen++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_digits"}, Digits, 24'h000000);
        chk({tag, "_ready"}, 24'(Load_Ready), 24'h1);
        chk({tag, "_blank"}, 24'(Blank), 24'(6'b111110));
        chk({tag, "_wrap"}, 24'(Wrap), 24'h0);
        chk({tag, "_err"}, 24'(Load_Err), 24'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wrap_seen   = 0;
        Reset_7Seg_n = 1'b1;
        En         = 1'b0;
        Up         = 1'b1;
        Clear      = 1'b0;
        Load_Valid = 1'b0;
        Load_Value = '0;
        model_reset();

        #1 Reset_7Seg_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (2) @(posedge CLOCK_50);
        #1 Reset_7Seg_n = 1'b1;
        repeat (3) cycle();

        En = 1'b1;
        Up = 1'b1;
        wrap_seen = 0;
        repeat (40) cycle();
        chk("count40_digits", Digits, 24'h000010);
        chk("count40_blank", 24'(Blank), 24'(6'b111100));
        chk("count40_nowrap", 24'(wrap_seen), 24'd0);

        En = 1'b0;
        Load_Valid = 1'b1;
        Load_Value = 24'h999998;
        cycle();
        Load_Valid = 1'b0;
        chk("load_up_holdoff", 24'(Load_Ready), 24'h0);
        En = 1'b1;
        wrap_seen = 0;
        repeat (8) cycle();
        chk("up_wrap_digits", Digits, 24'h000000);
        chk("up_wrap_blank", 24'(Blank), 24'(6'b111110));
        chk("up_wrap_once", 24'(wrap_seen), 24'd1);

        En = 1'b0;
        Up = 1'b0;
        Load_Valid = 1'b1;
        Load_Value = 24'h000001;
        cycle();
        Load_Valid = 1'b0;
        En = 1'b1;
        wrap_seen = 0;
        repeat (8) cycle();
        chk("down_wrap_digits", Digits, 24'h999999);
        chk("down_wrap_once", 24'(wrap_seen), 24'd1);

        En = 1'b0;
        Load_Valid = 1'b1;
        Load_Value = 24'h00000A;
        cycle();
        chk("bad_load_err", 24'(Load_Err), 24'h1);
        chk("bad_load_ready", 24'(Load_Ready), 24'h1);
        chk("bad_load_digits", Digits, 24'h999999);
        Load_Value = 24'h123456;
        cycle();
        chk("held_load_1_ready", 24'(Load_Ready), 24'h0);
        chk("held_load_1_digits", Digits, 24'h123456);
        cycle();
        chk("held_load_2_ready", 24'(Load_Ready), 24'h1);
        chk("held_load_2_err", 24'(Load_Err), 24'h0);
        Load_Valid = 1'b0;

        En = 1'b1;
        Up = 1'b1;
        repeat (3) cycle();
        Clear = 1'b1;
        Load_Valid = 1'b1;
        Load_Value = 24'h000005;
        cycle();
        chk("clr_all_digits", Digits, 24'h000000);
        chk("clr_all_wrap", 24'(Wrap), 24'h0);
        chk("clr_all_err", 24'(Load_Err), 24'h0);
        Clear = 1'b0;
        Load_Valid = 1'b0;
        repeat (3) cycle();
        chk("clr_presc_hold", Digits, 24'h000000);
        cycle();
        chk("clr_presc_tick", Digits, 24'h000001);

        for (int k = 0; k < 500; k++) begin
            En         = ($urandom % 4) != 0;
            Up         = 1'($urandom % 2);
            Clear      = ($urandom % 32) == 0;
            Load_Valid = ($urandom % 8) == 0;
            case ($urandom % 4)
                0: Load_Value = 24'($urandom);
                1: Load_Value = to_bcd(int'($urandom % MODN));
                2: Load_Value = to_bcd(MODN - 1 - int'($urandom % 2));
                default: Load_Value = to_bcd(int'($urandom % 2));
            endcase
            cycle();
        end

        Clear = 1'b0;
        Load_Valid = 1'b0;
        En = 1'b1;
        Up = 1'b1;
        repeat (2) cycle();
        #3 Reset_7Seg_n = 1'b0;
        #1 check_reset_vals("midreset");
        model_reset();
        En = 1'b0;
        @(posedge CLOCK_50);
        #1 Reset_7Seg_n = 1'b1;
        repeat (3) cycle();
        En = 1'b1;
        repeat (3) cycle();
        chk("release_no_tick", Digits, 24'h000000);
        cycle();
        chk("release_first_tick", Digits, 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
